// File: rtl/mul_issue_if.sv
// Bundle between the execute stage, the issue block, writeback and the
// downstream multiplier. The slave modport is the issue block itself.
interface mul_issue_if #(
   parameter int DATA_W = 64
);
   logic              in_valid;
   logic              in_ready;
   logic              in_word;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W:0]   m_multiplicand;
   logic [DATA_W:0]   m_multiplier;
   logic              m_out_valid;
   logic [DATA_W-1:0] m_result;

   modport master (
      output in_valid, in_word, in_a, in_b, flush, out_ready,
             m_ready, m_out_valid, m_result,
      input  in_ready, out_valid, out_data, m_valid, m_multiplicand, m_multiplier
   );

   modport slave (
      input  in_valid, in_word, in_a, in_b, flush, out_ready,
             m_ready, m_out_valid, m_result,
      output in_ready, out_valid, out_data, m_valid, m_multiplicand, m_multiplier
   );
endinterface

// File: rtl/mul_issue.sv
// Issues MUL/MULW requests to an external 65x65 signed multiplier, with a
// single-entry result cache that short-circuits repeated identical requests.
module mul_issue #(
   parameter int DATA_W = 64
) (
   input logic       clk,
   input logic       rst,
   mul_issue_if.slave bus
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

   state_t state, state_nxt;

   logic                     word_p0;
   logic signed [DATA_W-1:0] a_p0;
   logic signed [DATA_W-1:0] b_p0;
   logic signed [DATA_W-1:0] res_p1;

   logic                     c_vld;
   logic                     c_word;
   logic signed [DATA_W-1:0] c_a;
   logic signed [DATA_W-1:0] c_b;
   logic signed [DATA_W-1:0] c_res;

   logic accept;
   logic hit;
   logic capture;

   // MULW operands use only the low word, sign-extended to the 65-bit port.
   function automatic logic signed [DATA_W:0] form_op(input logic word,
                                                     input logic signed [DATA_W-1:0] x);
      if (word) return {{(DATA_W-31){x[31]}}, x[31:0]};
      return {x[DATA_W-1], x};
   endfunction

   function automatic logic signed [DATA_W-1:0] form_res(input logic word,
                                                        input logic [DATA_W-1:0] r);
      if (word) return {{(DATA_W-32){r[31]}}, r[31:0]};
      return r;
   endfunction

   assign accept  = bus.in_valid & bus.in_ready;
   assign hit     = c_vld & (c_word == bus.in_word) & (c_a == bus.in_a) & (c_b == bus.in_b);
   assign capture = (state == WAIT) & bus.m_out_valid & ~bus.flush;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (accept) state_nxt = hit ? DONE : ISSUE;
         ISSUE: if (bus.flush)        state_nxt = IDLE;
                else if (bus.m_ready) state_nxt = WAIT;
         WAIT:  if (bus.m_out_valid)  state_nxt = bus.flush ? IDLE : DONE;
                else if (bus.flush)   state_nxt = DRAIN;
         DONE:  if (bus.flush | bus.out_ready) state_nxt = IDLE;
         DRAIN: if (bus.m_out_valid)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready       = (state == IDLE)  & ~bus.flush;
      bus.m_valid        = (state == ISSUE) & ~bus.flush;
      bus.out_valid      = (state == DONE);
      bus.out_data       = res_p1;
      bus.m_multiplicand = form_op(word_p0, a_p0);
      bus.m_multiplier   = form_op(word_p0, b_p0);
   end

   // p0: request capture; p1: result register and cache update
   always_ff @(posedge clk) begin
      if (rst) begin
         word_p0 <= 1'b0;
         a_p0    <= '0;
         b_p0    <= '0;
         res_p1  <= '0;
         c_vld   <= 1'b0;
         c_word  <= 1'b0;
         c_a     <= '0;
         c_b     <= '0;
         c_res   <= '0;
      end else begin
         if (accept) begin
            word_p0 <= bus.in_word;
            a_p0    <= bus.in_a;
            b_p0    <= bus.in_b;
            if (hit) res_p1 <= c_res;
         end
         if (capture) begin
            res_p1 <= form_res(word_p0, bus.m_result);
            c_vld  <= 1'b1;
            c_word <= word_p0;
            c_a    <= a_p0;
            c_b    <= b_p0;
            c_res  <= form_res(word_p0, bus.m_result);
         end
      end
   end

endmodule

// File: tb/tb_mul_issue.sv
// Directed and randomized checks of mul_issue against a arithmetic reference
// model, with the bench playing execute stage, writeback and multiplier.
module tb_mul_issue;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mul_issue_if bus ();

   mul_issue dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // reference cache: the last request whose result came back from the multiplier
   logic        rc_vld = 1'b0;
   logic        rc_w   = 1'b0;
   logic [63:0] rc_a   = '0;
   logic [63:0] rc_b   = '0;

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ref_mul(input logic w, input logic [63:0] a, input logic [63:0] b);
      logic [31:0] lo;
      logic [63:0] full;
      if (w) begin
         lo = a[31:0] * b[31:0];
         return {{32{lo[31]}}, lo};
      end
      full = a * b;
      return full;
   endfunction

   function automatic logic [64:0] ref_op(input logic w, input logic [63:0] x);
      logic signed [64:0] v;
      if (w) v = $signed(x[31:0]);
      else   v = $signed(x);
      return v;
   endfunction

   // multiplier behaviour: low 64 bits of the signed 65x65 product
   function automatic logic [63:0] mult_model(input logic [64:0] p, input logic [64:0] q);
      logic [129:0] pr;
      pr = {{65{p[64]}}, p} * {{65{q[64]}}, q};
      return pr[63:0];
   endfunction

   task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] b,
                         input int stall, input int lat, input int hold);
      logic        hit;
      logic [63:0] expv;
      expv = ref_mul(w, a, b);
      hit  = rc_vld && (rc_w == w) && (rc_a == a) && (rc_b == b);
      bus.in_valid = 1'b1; bus.in_word = w; bus.in_a = a; bus.in_b = b;
      #2;
      chk("in_ready_idle", bus.in_ready, 1);
      cyc();
      bus.in_valid = 1'b0; bus.in_a = {$urandom, $urandom}; bus.in_b = {$urandom, $urandom};
      if (!hit) begin
         bus.m_ready = 1'b0;
         for (int i = 0; i < stall; i++) begin
            #2; chk("m_valid_stall", bus.m_valid, 1); cyc();
         end
         bus.m_ready = 1'b1;
         #2;
         chk("m_valid_issue", bus.m_valid, 1);
         chk("m_multiplicand", bus.m_multiplicand, ref_op(w, a));
         chk("m_multiplier", bus.m_multiplier, ref_op(w, b));
         cyc();
         for (int i = 0; i < lat; i++) begin
            #2;
            chk("wait_quiet", {bus.out_valid, bus.m_valid, bus.in_ready}, 0);
            chk("wait_op_stable", bus.m_multiplicand, ref_op(w, a));
            cyc();
         end
         bus.m_out_valid = 1'b1;
         bus.m_result    = mult_model(ref_op(w, a), ref_op(w, b));
         cyc();
         bus.m_out_valid = 1'b0; bus.m_result = {$urandom, $urandom};
         rc_vld = 1'b1; rc_w = w; rc_a = a; rc_b = b;
      end
      #2;
      chk("out_valid", bus.out_valid, 1);
      chk("out_data", bus.out_data, expv);
      chk("m_valid_done", bus.m_valid, 0);
      for (int k = 0; k < hold; k++) begin
         cyc(); #2;
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_data", bus.out_data, expv);
      end
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      #2;
      chk("back_idle", {bus.in_ready, bus.out_valid}, 2'b10);
   endtask

   initial begin
      logic        w;
      logic [63:0] a, b;

      bus.in_valid = 1'b0; bus.in_word = 1'b0; bus.in_a = '0; bus.in_b = '0;
      bus.flush = 1'b0; bus.out_ready = 1'b0; bus.m_ready = 1'b1;
      bus.m_out_valid = 1'b0; bus.m_result = '0;
      cyc(); cyc();
      rst = 1'b0;
      #2;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_operand", bus.m_multiplicand, 0);

      // m_out_valid outside WAIT/DRAIN is ignored
      cyc();
      bus.m_out_valid = 1'b1; bus.m_result = 64'hDEAD_BEEF;
      cyc();
      bus.m_out_valid = 1'b0;
      #2;
      chk("stray_m_out", {bus.in_ready, bus.out_valid}, 2'b10);

      // MUL with a negative operand
      cyc();
      do_req(1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0, 0);
      chk("mul_neg_expect", ref_mul(1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB), 64'hFFFF_FFFF_FFFF_FFF1);
      // identical request: served from the cache in one cycle
      cyc();
      do_req(1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0, 0);
      chk("cache_out_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FFF1);

      // MULW ignores the upper half and sign-extends the low-word product
      cyc();
      bus.in_valid = 1'b1; bus.in_word = 1'b1; bus.in_a = 64'h1234_5678_7FFF_FFFF; bus.in_b = 64'd2;
      cyc();
      bus.in_valid = 1'b0;
      #2;
      chk("mulw_operand", bus.m_multiplicand, 65'h0_0000_0000_7FFF_FFFF);
      cyc();
      bus.m_out_valid = 1'b1; bus.m_result = 64'h0000_0000_FFFF_FFFE;
      cyc();
      bus.m_out_valid = 1'b0;
      #2;
      chk("mulw_out_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FFFE);
      bus.out_ready = 1'b1; cyc(); bus.out_ready = 1'b0;
      rc_vld = 1'b1; rc_w = 1'b1; rc_a = 64'h1234_5678_7FFF_FFFF; rc_b = 64'd2;

      // writeback back-pressure for 5 cycles
      cyc();
      do_req(1'b0, 64'h0000_0001_0000_0003, 64'h0000_0000_0000_0007, 1, 2, 5);

      // flush in WAIT leads to DRAIN, result dropped, cache untouched
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      cyc();
      bus.in_valid = 1'b1; bus.in_word = 1'b0; bus.in_a = a; bus.in_b = b;
      cyc();
      bus.in_valid = 1'b0;
      #2; chk("flush_issue_mv", bus.m_valid, 1);
      cyc();
      cyc();
      bus.flush = 1'b1;
      cyc();
      #2; chk("drain_flush_ready", bus.in_ready, 0);
      cyc();
      bus.flush = 1'b0;
      #2; chk("drain_ready", {bus.in_ready, bus.out_valid}, 0);
      cyc();
      bus.m_out_valid = 1'b1; bus.m_result = {$urandom, $urandom};
      #2; chk("drain_ready_mov", {bus.in_ready, bus.out_valid}, 0);
      cyc();
      bus.m_out_valid = 1'b0;
      #2; chk("drain_exit", {bus.in_ready, bus.out_valid}, 2'b10);
      do_req(1'b0, a, b, 0, 1, 0);

      // flush while stalled in ISSUE: no transfer, back to IDLE
      cyc();
      bus.in_valid = 1'b1; bus.in_word = 1'b1; bus.in_a = 64'd11; bus.in_b = 64'd13;
      cyc();
      bus.in_valid = 1'b0; bus.m_ready = 1'b0;
      cyc();
      bus.flush = 1'b1; bus.m_ready = 1'b1;
      #2; chk("flush_issue_no_mv", bus.m_valid, 0);
      cyc();
      bus.flush = 1'b0;
      #2; chk("flush_issue_idle", {bus.in_ready, bus.m_valid}, 2'b10);

      // flush in DONE (cache hit) drops out_valid
      bus.in_valid = 1'b1; bus.in_word = 1'b0; bus.in_a = a; bus.in_b = b;
      cyc();
      bus.in_valid = 1'b0;
      #2; chk("done_hit_valid", {bus.out_valid, bus.m_valid}, 2'b10);
      bus.flush = 1'b1; bus.out_ready = 1'b1;
      cyc();
      bus.flush = 1'b0; bus.out_ready = 1'b0;
      #2; chk("done_flush", {bus.in_ready, bus.out_valid}, 2'b10);

      // reset in WAIT clears state and cache
      bus.in_valid = 1'b1; bus.in_word = 1'b0; bus.in_a = a; bus.in_b = b;
      cyc();
      bus.in_valid = 1'b1; bus.in_a = 64'd5; bus.in_b = 64'd9;
      bus.in_valid = 1'b0;
      chk("hit_before_rst", bus.out_valid, 1);
      bus.out_ready = 1'b1; cyc(); bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_a = 64'd5; bus.in_b = 64'd9;
      cyc();
      bus.in_valid = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #2;
      chk("rst_wait", {bus.in_ready, bus.out_valid, bus.m_valid}, 3'b100);
      chk("rst_wait_data", bus.out_data, 0);
      rc_vld = 1'b0;
      do_req(1'b0, a, b, 0, 1, 0);

      // randomized traffic, with deliberate repeats to exercise the cache
      for (int n = 0; n < 30; n++) begin
         if (rc_vld && $urandom_range(0, 2) == 0) begin
            w = rc_w; a = rc_a; b = rc_b;
         end else begin
            w = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
         end
         cyc();
         do_req(w, a, b, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
